sc_datamem_io: RTL
==================

# sc_datamem_io

Parametrised data-memory and memory-mapped I/O bridge for the single-cycle and pipelined CPU cores. It gives the core a word-addressed data RAM with byte-lane stores. Above the RAM, in the same address space, it maps output registers, synchronised input ports and optional sticky edge-capture registers. Reads complete through a registered one-cycle-latency port, so the block sits between the core's load/store unit and the board pins.

## Interface
- ADDR_W, 8, byte-address width decoded; `addr[ADDR_W-1]` selects I/O; RAM depth `2**(ADDR_W-3)` words; must be >= 8
- IN_CH, 2, number of input channels, 1..8
- IN_W, 5, bits per input channel, 1..32
- OUT_CH, 3, number of output channels, 1..8
- OUT_W, 8, bits per output channel, 1..32

- clock  in  1  single clock; all state updates on rising edge
- resetn  in  1  asynchronous, active-low reset
- req  in  1  access request this cycle
- we  in  1  write when `req=1`; read otherwise
- be  in  4  byte-lane enables for writes; `be[i]` covers `datain[8i+7:8i]`
- addr  in  ADDR_W  byte address; `addr[1:0]` ignored
- datain  in  32  write data
- dataout  out  32  read data, registered
- rvalid  out  1  `dataout` valid for the read accepted on the previous edge
- io_in  in  IN_CH*IN_W  raw asynchronous inputs; channel c = `io_in[c*IN_W +: IN_W]`
- io_out  out  OUT_CH*OUT_W  output registers; channel c = `io_out[c*OUT_W +: OUT_W]`

## Operation
- Word index `idx = addr[ADDR_W-2:2]`.
- RAM region (`addr[ADDR_W-1]=0`):
  - Write: each lane with `be[i]=1` is updated; other lanes are unchanged.
  - Read: returns the full word. Contents are not reset.
- I/O region (`addr[ADDR_W-1]=1`), indexed by `idx[4:0]`:
  - 0..OUT_CH-1: output register c, read/write. Byte lanes apply. Bits at and above OUT_W are ignored on write and read as 0.
  - 8..8+IN_CH-1: synchronised input channel c, read-only, zero-extended.
  - 16..16+IN_CH-1: edge-capture register c (macro-dependent, see Configuration).
  - All other indices read 0; writes to them are ignored.
- Inputs pass through a 2-FF synchroniser per bit (`sync1`, `sync2`) before any use.
- Read of a location written in the same cycle returns the old data (read-first).
- The block accepts one request every cycle; no back-pressure.

## Timing
- Reset (`resetn=0`, asynchronous):
  - `dataout=0`, `rvalid=0`, `io_out=0`.
  - Synchronisers, edge-prev registers and edge-capture registers all cleared.
  - A read in flight when reset asserts is dropped: `rvalid` stays 0 after release.
- Read accepted at edge k:
  - `dataout` and `rvalid=1` are valid after edge k.
  - With no read accepted at an edge, `rvalid=0` and `dataout` holds its last value.
- Write accepted at edge k: the target updates at edge k. For output channels, `io_out` shows the new value after edge k.
- `io_in` change sampled at edge k: `sync2` updates at edge k+1. A read accepted at edge k+2 or later returns the new value.
- Edge capture: sets at edge k+2 when `sync2` rises against its one-cycle-delayed copy.

## Configuration
- Macro `SC_DATAMEM_IO_EDGE_EN`.
- Defined:
  - Per input bit, a rising edge of `sync2` sets the sticky bit in edge-capture register c.
  - Write-1-to-clear via lane-enabled writes; writing 0 has no effect.
  - If a set and a clear hit the same bit on the same edge, the set wins (bit stays 1).
- Undefined: no edge logic is synthesised; indices 16..23 read 0 and writes to them are ignored.

## Test plan
- Reset then RAM write/read: write `0xDEADBEEF` to byte addr `0x10`, `be=4'hF`; read `0x10` -> `rvalid=1` one cycle later, `dataout=0xDEADBEEF`.
- Byte lanes: RAM holds `0xDEADBEEF`; write `0x00001200` with `be=4'b0010` -> read returns `0xDEAD12EF`.
- Output channel: write `0x1A5` to I/O index 1 (addr `0x84`) -> after that edge `io_out[15:8]=0xA5`; read returns `0x000000A5`; other channels stay 0.
- Input sync: set `io_in[9:5]=5'h13` -> a read of addr `0xA4` accepted one edge after sampling still returns 0; a read accepted two edges after sampling returns `0x13`.
- Edge capture (macro defined): pulse `io_in[0]` 0->1 -> read addr `0xC0` returns `0x1`. Write `0x1` while a new rising edge arrives the same cycle -> bit stays 1. A later write of `0x1` clears it to 0. With the macro undefined, the same reads return 0.
- Reset mid-read: issue a read, assert `resetn=0` before the next edge -> `rvalid=0`, `dataout=0`, `io_out=0` immediately and after release.

Source files
------------

// File: rtl/sc_datamem_io.sv
// Data RAM plus memory-mapped output, synchronised input and edge-capture registers.
// Optional edge capture is built only when SC_DATAMEM_IO_EDGE_EN is defined.
module sc_datamem_io #(
  parameter int ADDR_W = 8,
  parameter int IN_CH  = 2,
  parameter int IN_W   = 5,
  parameter int OUT_CH = 3,
  parameter int OUT_W  = 8
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic                    req,
  input  logic                    we,
  input  logic [3:0]              be,
  input  logic [ADDR_W-1:0]       addr,
  input  logic [31:0]             datain,
  output logic [31:0]             dataout,
  output logic                    rvalid,
  input  logic [IN_CH*IN_W-1:0]   io_in,
  output logic [OUT_CH*OUT_W-1:0] io_out
);

  localparam int IDX_W = ADDR_W - 3;
  localparam int DEPTH = 1 << IDX_W;

  typedef logic [IN_CH-1:0][IN_W-1:0] in_arr_t;

  logic              io_sel;
  logic [IDX_W-1:0]  idx;
  logic [4:0]        io_idx;
  logic              wr;
  logic              rd;
  logic [31:0]       wmask;
  logic [31:0]       io_rdata;
  logic [31:0]       rdata;
  logic              unused;

  assign io_sel = addr[ADDR_W-1];
  assign idx    = addr[ADDR_W-2:2];
  assign io_idx = idx[4:0];
  assign wr     = req & we;
  assign rd     = req & ~we;
  assign wmask  = {{8{be[3]}}, {8{be[2]}},
                   {8{be[1]}}, {8{be[0]}}};
  assign unused = ^addr[1:0];

  function automatic logic [31:0] merge(
    input logic [31:0] old_v,
    input logic [31:0] new_v,
    input logic [31:0] m
  );
    return (old_v & ~m) | (new_v & m);
  endfunction

  // Data RAM: contents survive reset
  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clock) begin
    if (wr && !io_sel) begin
      mem_q[idx] <= merge(mem_q[idx], datain, wmask);
    end
  end

  // Output registers
  logic [OUT_CH-1:0][OUT_W-1:0] out_q, out_d;

  always_comb begin
    out_d = out_q;
    if (wr && io_sel) begin
      for (int c = 0; c < OUT_CH; c++) begin
        if (io_idx == 5'(c)) begin
          out_d[c] = OUT_W'(merge(32'(out_q[c]), datain, wmask));
        end
      end
    end
  end

  assign io_out = out_q;

  // Two-flop synchroniser
  in_arr_t sync1_q, sync2_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync1_q <= '0;
      sync2_q <= '0;
      out_q   <= '0;
    end else begin
      sync1_q <= io_in;
      sync2_q <= sync1_q;
      out_q   <= out_d;
    end
  end

  in_arr_t cap_v;

`ifdef SC_DATAMEM_IO_EDGE_EN
  in_arr_t prev_q, cap_q, cap_d, clr;

  // Set has priority over a same-edge write-1-to-clear
  always_comb begin
    clr = '0;
    if (wr && io_sel) begin
      for (int c = 0; c < IN_CH; c++) begin
        if (io_idx == 5'(16 + c)) begin
          clr[c] = IN_W'(datain & wmask);
        end
      end
    end
    cap_d = (cap_q & ~clr) | (sync2_q & ~prev_q);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      prev_q <= '0;
      cap_q  <= '0;
    end else begin
      prev_q <= sync2_q;
      cap_q  <= cap_d;
    end
  end

  assign cap_v = cap_q;
`else
  assign cap_v = '0;
`endif

  always_comb begin
    io_rdata = '0;
    for (int c = 0; c < OUT_CH; c++) begin
      if (io_idx == 5'(c)) io_rdata = 32'(out_q[c]);
    end
    for (int c = 0; c < IN_CH; c++) begin
      if (io_idx == 5'(8 + c))  io_rdata = 32'(sync2_q[c]);
      if (io_idx == 5'(16 + c)) io_rdata = 32'(cap_v[c]);
    end
    rdata = io_sel ? io_rdata : mem_q[idx];
  end

  logic [31:0] dataout_q;
  logic        rvalid_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      dataout_q <= '0;
      rvalid_q  <= 1'b0;
    end else begin
      rvalid_q <= rd;
      if (rd) dataout_q <= rdata;
    end
  end

  assign dataout = dataout_q;
  assign rvalid  = rvalid_q;

endmodule
